core_l1d_port: RTL and testbench
================================

# core_l1d_port

Request/response port between the core pipeline's memory-stage L1D interface and the L1D cache. It registers one data-memory request, holds it until the cache accepts it, and tracks the single outstanding transaction until the cache acknowledges. It returns the registered ack and read data to the pipeline. It tags each request as non-cacheable using the NC base/mask CSRs and bounds the wait for the ack with a timeout that reports an error.

## Interface
- TMO_CYCLES, 255: cycles spent in WAIT without an ack before an error response; legal range 1..65535.
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- csr_nc_base  in  32  non-cacheable region base.
- csr_nc_mask  in  32  non-cacheable region mask.
- core_req_val  in  1  pipeline request valid.
- core_req_rdy  out  1  port can accept a request.
- core_req_addr  in  32  byte address.
- core_req_cop  in  3  operation: 3'b000 read, 3'b001 write; other codes are forwarded unchanged.
- core_req_size  in  3  access size: 3'b000 byte, 3'b001 half, 3'b010 word.
- core_req_wdata  in  32  store data.
- core_ack  out  1  one-cycle response pulse.
- core_ack_err  out  1  error qualifier for core_ack (timeout or misaligned).
- core_ack_rdata  out  32  read data, valid with core_ack.
- l1d_req_val  out  1  request to the cache.
- l1d_req_rdy  in  1  cache accepts the request this cycle.
- l1d_req_addr  out  32  registered address.
- l1d_req_cop  out  3  registered operation.
- l1d_req_size  out  3  registered size.
- l1d_req_wdata  out  32  registered store data.
- l1d_req_nc  out  1  ((addr & csr_nc_mask) == (csr_nc_base & csr_nc_mask)), evaluated at accept.
- l1d_ack  in  1  cache response.
- l1d_ack_rdata  in  32  cache read data.

## Operation
- States: IDLE, REQ, WAIT. At most one transaction is outstanding.
- core_req_rdy = (state == IDLE).
- IDLE:
  - core_req_val=1: capture addr, cop, size, wdata and nc into registers; go to REQ.
- REQ:
  - l1d_req_val=1; the l1d_req_* outputs come from the capture registers and are stable while waiting.
  - l1d_req_rdy=1: go to WAIT and clear the timeout counter.
  - l1d_ack in REQ is ignored.
- WAIT:
  - The counter increments each cycle.
  - l1d_ack=1: register l1d_ack_rdata; core_ack=1 and core_ack_err=0 next cycle; go to IDLE.
  - Counter reaches TMO_CYCLES with no ack: core_ack=1, core_ack_err=1 and core_ack_rdata=0 next cycle; go to IDLE.
  - If l1d_ack arrives in the same cycle the counter expires, the ack wins and err=0.
- l1d_ack arriving in IDLE (for example, late after a timeout) is ignored and produces no core_ack.
- Write responses return core_ack with core_ack_rdata = l1d_ack_rdata; the pipeline ignores this data.
- The counter width is clog2(TMO_CYCLES+1) and it saturates; it does not wrap.
- The CSRs are sampled only at accept. Changing them later does not affect an in-flight l1d_req_nc.

## Timing
- Reset values: state=IDLE; core_req_rdy=1; core_ack=0; core_ack_err=0; core_ack_rdata=0; l1d_req_val=0; l1d_req_addr, cop, size and wdata all 0; l1d_req_nc=0; counter=0.
- Accept at edge T: l1d_req_val=1 from T+1.
- l1d_req_rdy sampled at edge R: l1d_req_val=0 from R+1.
- l1d_ack sampled at edge A: core_ack is high for exactly cycle A+1; core_req_rdy=1 in the same cycle.
  - A new request can be accepted at edge A+1, so back-to-back requests are issued at most every 3 cycles when the cache responds with zero wait.
- Reset asserted mid-transaction: all state is cleared immediately; the outstanding request is dropped with no core_ack; any later l1d_ack is ignored.

## Configuration
- CORE_L1D_MISALIGN_CHK_EN defined:
  - An accepted half access with addr[0]=1, or word access with addr[1:0]!=0, is not sent to L1D (l1d_req_val stays 0).
  - core_ack=1, core_ack_err=1, rdata=0 in the cycle after accept; state stays IDLE.
  - Size 3'b011 and above are also flagged as misaligned.
- CORE_L1D_MISALIGN_CHK_EN not defined: all requests are forwarded unchanged and misaligned accesses are the cache's concern.

## Test plan
- Word read at addr 0x100, with L1D giving rdy at the first REQ cycle and ack rdata 0xDEADBEEF two cycles later -> l1d_req_val high for 1 cycle with addr 0x100, cop 0, size 2; core_ack=1 err=0 rdata 0xDEADBEEF one cycle after the ack.
- Write with wdata 0x12345678 and l1d_req_rdy held low for 5 cycles -> l1d_req_val high for 6 cycles with addr/wdata stable; core_req_rdy=0 throughout.
- NC tagging with base 0x8000_0000 and mask 0xF000_0000: addr 0x8000_0010 -> l1d_req_nc=1; addr 0x4000_0010 -> l1d_req_nc=0.
- Timeout with TMO_CYCLES=4 and no ack -> core_ack=1 err=1 rdata 0; a stray l1d_ack 3 cycles later produces no core_ack; the next request proceeds normally.
- Misalignment: word read at 0x102 with the macro defined -> no l1d_req_val; core_ack err=1 next cycle. The same stimulus without the macro -> forwarded with addr 0x102.
- rst_n pulsed low during WAIT -> all outputs return to reset values asynchronously; an ack after reset release produces no core_ack.

Source files
------------

// File: rtl/core_l1d_port.sv
// core_l1d_port
//
// Purpose: bridges the core memory-stage request to the L1D cache. One
// request is captured, presented to the cache until it is accepted, then
// tracked until the cache acknowledges or a timeout expires. The response
// (ack, error flag, read data) is registered and returned to the pipeline
// as a single-cycle pulse.
//
// Handshakes: a transfer on core_req_* happens on a rising edge where
// core_req_val && core_req_rdy; a transfer on l1d_req_* happens on a rising
// edge where l1d_req_val && l1d_req_rdy. Once l1d_req_val rises, the
// l1d_req_* payload is held stable until the transfer. l1d_ack is only
// honoured while a transaction is outstanding (WAIT).
//
// Parameters:
//   TMO_CYCLES  cycles spent in WAIT without an ack before an error
//               response (1..65535).
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   csr_nc_base, csr_nc_mask       non-cacheable region, sampled at accept
//   core_req_val/rdy/addr/cop/size/wdata   pipeline request
//   core_ack, core_ack_err, core_ack_rdata pipeline response pulse
//   l1d_req_val/rdy/addr/cop/size/wdata/nc cache request
//   l1d_ack, l1d_ack_rdata                 cache response
//
// Optional feature (macro CORE_L1D_MISALIGN_CHK_EN): misaligned half/word
// accesses and sizes >= 3'b011 are answered locally with an error response
// the cycle after accept and never reach the cache.

module core_l1d_port #(
  parameter int TMO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] csr_nc_base,
  input  logic [31:0] csr_nc_mask,
  input  logic        core_req_val,
  output logic        core_req_rdy,
  input  logic [31:0] core_req_addr,
  input  logic [2:0]  core_req_cop,
  input  logic [2:0]  core_req_size,
  input  logic [31:0] core_req_wdata,
  output logic        core_ack,
  output logic        core_ack_err,
  output logic [31:0] core_ack_rdata,
  output logic        l1d_req_val,
  input  logic        l1d_req_rdy,
  output logic [31:0] l1d_req_addr,
  output logic [2:0]  l1d_req_cop,
  output logic [2:0]  l1d_req_size,
  output logic [31:0] l1d_req_wdata,
  output logic        l1d_req_nc,
  input  logic        l1d_ack,
  input  logic [31:0] l1d_ack_rdata
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;

  localparam int CW = $clog2(TMO_CYCLES + 1);
  // Timeout fires on the edge where the counter would reach TMO_CYCLES,
  // i.e. after exactly TMO_CYCLES cycles in WAIT.
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TMO_CYCLES);

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    cop_q, cop_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          nc_q, nc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          ack_err_q, ack_err_d;
  logic [31:0]   ack_rdata_q, ack_rdata_d;

  logic          nc_hit;
  logic          misalign;

  assign nc_hit = ((core_req_addr & csr_nc_mask) == (csr_nc_base & csr_nc_mask));

`ifdef CORE_L1D_MISALIGN_CHK_EN
  assign misalign = (core_req_size >= 3'b011) ||
                    ((core_req_size == 3'b001) && core_req_addr[0]) ||
                    ((core_req_size == 3'b010) && (core_req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cop_d       = cop_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    nc_d        = nc_q;
    cnt_d       = cnt_q;
    ack_d       = 1'b0;
    ack_err_d   = 1'b0;
    ack_rdata_d = ack_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (core_req_val) begin
          if (misalign) begin
            // Answered locally; nothing is sent to the cache.
            ack_d       = 1'b1;
            ack_err_d   = 1'b1;
            ack_rdata_d = 32'h0;
          end else begin
            addr_d  = core_req_addr;
            cop_d   = core_req_cop;
            size_d  = core_req_size;
            wdata_d = core_req_wdata;
            nc_d    = nc_hit;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (l1d_req_rdy) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        // Ack is checked first so it wins over a same-cycle expiry.
        if (l1d_ack) begin
          ack_d       = 1'b1;
          ack_rdata_d = l1d_ack_rdata;
          state_d     = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          ack_d       = 1'b1;
          ack_err_d   = 1'b1;
          ack_rdata_d = 32'h0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cop_q       <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      nc_q        <= 1'b0;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      ack_err_q   <= 1'b0;
      ack_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cop_q       <= cop_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      nc_q        <= nc_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      ack_err_q   <= ack_err_d;
      ack_rdata_q <= ack_rdata_d;
    end
  end

  assign core_req_rdy   = (state_q == ST_IDLE);
  assign core_ack       = ack_q;
  assign core_ack_err   = ack_err_q;
  assign core_ack_rdata = ack_rdata_q;
  assign l1d_req_val    = (state_q == ST_REQ);
  assign l1d_req_addr   = addr_q;
  assign l1d_req_cop    = cop_q;
  assign l1d_req_size   = size_q;
  assign l1d_req_wdata  = wdata_q;
  assign l1d_req_nc     = nc_q;

endmodule

// File: tb/tb_core_l1d_port.sv
module tb_core_l1d_port;

  logic        clk;
  logic        rst_n;
  logic [31:0] csr_nc_base;
  logic [31:0] csr_nc_mask;
  logic        core_req_val;
  logic        core_req_rdy;
  logic [31:0] core_req_addr;
  logic [2:0]  core_req_cop;
  logic [2:0]  core_req_size;
  logic [31:0] core_req_wdata;
  logic        core_ack;
  logic        core_ack_err;
  logic [31:0] core_ack_rdata;
  logic        l1d_req_val;
  logic        l1d_req_rdy;
  logic [31:0] l1d_req_addr;
  logic [2:0]  l1d_req_cop;
  logic [2:0]  l1d_req_size;
  logic [31:0] l1d_req_wdata;
  logic        l1d_req_nc;
  logic        l1d_ack;
  logic [31:0] l1d_ack_rdata;

  int checks = 0;
  int errors = 0;

  core_l1d_port #(.TMO_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_nc_base(csr_nc_base), .csr_nc_mask(csr_nc_mask),
    .core_req_val(core_req_val), .core_req_rdy(core_req_rdy),
    .core_req_addr(core_req_addr), .core_req_cop(core_req_cop),
    .core_req_size(core_req_size), .core_req_wdata(core_req_wdata),
    .core_ack(core_ack), .core_ack_err(core_ack_err), .core_ack_rdata(core_ack_rdata),
    .l1d_req_val(l1d_req_val), .l1d_req_rdy(l1d_req_rdy),
    .l1d_req_addr(l1d_req_addr), .l1d_req_cop(l1d_req_cop),
    .l1d_req_size(l1d_req_size), .l1d_req_wdata(l1d_req_wdata),
    .l1d_req_nc(l1d_req_nc),
    .l1d_ack(l1d_ack), .l1d_ack_rdata(l1d_ack_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // drivers: inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [2:0] cop,
                       input logic [2:0] size, input logic [31:0] wdata);
    core_req_val   = 1'b1;
    core_req_addr  = addr;
    core_req_cop   = cop;
    core_req_size  = size;
    core_req_wdata = wdata;
    tick();
    core_req_val   = 1'b0;
  endtask

  // From REQ: cache accepts immediately, acks on the next WAIT cycle.
  task automatic finish_ok(input string tag, input logic [31:0] rdata);
    l1d_req_rdy = 1'b1;
    tick();
    l1d_req_rdy   = 1'b0;
    l1d_ack       = 1'b1;
    l1d_ack_rdata = rdata;
    tick();
    l1d_ack = 1'b0;
    chk({tag, "_ack"}, {31'b0, core_ack}, 32'd1);
    chk({tag, "_err"}, {31'b0, core_ack_err}, 32'd0);
    chk({tag, "_rdata"}, core_ack_rdata, rdata);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; csr_nc_base = 32'h0; csr_nc_mask = 32'h0;
    core_req_val = 1'b0; core_req_addr = 32'h0; core_req_cop = 3'b0;
    core_req_size = 3'b0; core_req_wdata = 32'h0;
    l1d_req_rdy = 1'b0; l1d_ack = 1'b0; l1d_ack_rdata = 32'h0;
    #12;
    // reset state
    chk("rst_rdy", {31'b0, core_req_rdy}, 32'd1);
    chk("rst_ack", {31'b0, core_ack}, 32'd0);
    chk("rst_l1d_val", {31'b0, l1d_req_val}, 32'd0);
    chk("rst_addr", l1d_req_addr, 32'h0);
    chk("rst_rdata", core_ack_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: word read at 0x100, rdy at first REQ cycle, ack two cycles later
    issue(32'h100, 3'b000, 3'b010, 32'h0);
    chk("rd_val", {31'b0, l1d_req_val}, 32'd1);
    chk("rd_addr", l1d_req_addr, 32'h100);
    chk("rd_cop", {29'b0, l1d_req_cop}, 32'd0);
    chk("rd_size", {29'b0, l1d_req_size}, 32'd2);
    chk("rd_busy", {31'b0, core_req_rdy}, 32'd0);
    l1d_req_rdy = 1'b1;
    tick();
    l1d_req_rdy = 1'b0;
    chk("rd_val_drop", {31'b0, l1d_req_val}, 32'd0);
    tick();
    chk("rd_no_early_ack", {31'b0, core_ack}, 32'd0);
    l1d_ack = 1'b1; l1d_ack_rdata = 32'hDEADBEEF;
    tick();
    l1d_ack = 1'b0;
    chk("rd_ack", {31'b0, core_ack}, 32'd1);
    chk("rd_err", {31'b0, core_ack_err}, 32'd0);
    chk("rd_rdata", core_ack_rdata, 32'hDEADBEEF);
    chk("rd_rdy_with_ack", {31'b0, core_req_rdy}, 32'd1);
    tick();
    chk("rd_ack_pulse", {31'b0, core_ack}, 32'd0);

    // 2: write, cache stalls 5 cycles -> l1d_req_val high 6 cycles
    issue(32'h200, 3'b001, 3'b010, 32'h12345678);
    core_req_addr = 32'hFFFF_FFFC; core_req_wdata = 32'h0; // must not leak
    for (int i = 0; i < 6; i++) begin
      chk("wr_val", {31'b0, l1d_req_val}, 32'd1);
      chk("wr_busy", {31'b0, core_req_rdy}, 32'd0);
      chk("wr_addr", l1d_req_addr, 32'h200);
      chk("wr_wdata", l1d_req_wdata, 32'h12345678);
      if (i == 5) l1d_req_rdy = 1'b1;
      tick();
    end
    l1d_req_rdy = 1'b0;
    chk("wr_val_drop", {31'b0, l1d_req_val}, 32'd0);
    l1d_ack = 1'b1; l1d_ack_rdata = 32'h5A5A5A5A;
    tick();
    l1d_ack = 1'b0;
    chk("wr_ack", {31'b0, core_ack}, 32'd1);
    chk("wr_rdata", core_ack_rdata, 32'h5A5A5A5A);
    tick();

    // 3: NC tagging, CSRs sampled only at accept
    csr_nc_base = 32'h8000_0000; csr_nc_mask = 32'hF000_0000;
    issue(32'h8000_0010, 3'b000, 3'b010, 32'h0);
    chk("nc_hit", {31'b0, l1d_req_nc}, 32'd1);
    csr_nc_base = 32'h1000_0000;
    tick();
    chk("nc_held", {31'b0, l1d_req_nc}, 32'd1);
    finish_ok("nc1", 32'h0000_1111);
    csr_nc_base = 32'h8000_0000;
    issue(32'h4000_0010, 3'b000, 3'b010, 32'h0);
    chk("nc_miss", {31'b0, l1d_req_nc}, 32'd0);
    finish_ok("nc2", 32'h0000_2222);

    // 4: timeout with TMO_CYCLES=4
    issue(32'h300, 3'b000, 3'b010, 32'h0);
    l1d_req_rdy = 1'b1;
    tick();
    l1d_req_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo_wait", {31'b0, core_ack}, 32'd0);
    end
    tick();
    chk("tmo_ack", {31'b0, core_ack}, 32'd1);
    chk("tmo_err", {31'b0, core_ack_err}, 32'd1);
    chk("tmo_rdata", core_ack_rdata, 32'h0);
    chk("tmo_idle", {31'b0, core_req_rdy}, 32'd1);
    tick();
    tick();
    l1d_ack = 1'b1; l1d_ack_rdata = 32'hBAD0BAD0;
    tick();
    l1d_ack = 1'b0;
    chk("stray_ack", {31'b0, core_ack}, 32'd0);
    tick();
    chk("stray_ack2", {31'b0, core_ack}, 32'd0);
    issue(32'h304, 3'b000, 3'b010, 32'h0);
    chk("after_tmo_val", {31'b0, l1d_req_val}, 32'd1);
    finish_ok("after_tmo", 32'hCAFEF00D);

    // 4b: ack on the same edge the counter expires -> ack wins
    issue(32'h308, 3'b000, 3'b010, 32'h0);
    l1d_req_rdy = 1'b1;
    tick();
    l1d_req_rdy = 1'b0;
    tick(); tick(); tick();
    chk("race_wait", {31'b0, core_ack}, 32'd0);
    l1d_ack = 1'b1; l1d_ack_rdata = 32'h0BADF00D;
    tick();
    l1d_ack = 1'b0;
    chk("race_ack", {31'b0, core_ack}, 32'd1);
    chk("race_err", {31'b0, core_ack_err}, 32'd0);
    chk("race_rdata", core_ack_rdata, 32'h0BADF00D);
    tick();

    // 5: misaligned word read at 0x102
    issue(32'h102, 3'b000, 3'b010, 32'h0);
`ifdef CORE_L1D_MISALIGN_CHK_EN
    chk("mis_no_val", {31'b0, l1d_req_val}, 32'd0);
    chk("mis_ack", {31'b0, core_ack}, 32'd1);
    chk("mis_err", {31'b0, core_ack_err}, 32'd1);
    chk("mis_rdata", core_ack_rdata, 32'h0);
    chk("mis_idle", {31'b0, core_req_rdy}, 32'd1);
    tick();
`else
    chk("mis_val", {31'b0, l1d_req_val}, 32'd1);
    chk("mis_addr", l1d_req_addr, 32'h102);
    chk("mis_no_ack", {31'b0, core_ack}, 32'd0);
    finish_ok("mis", 32'h7777_0102);
`endif

    // 6: reset pulsed during WAIT
    issue(32'h400, 3'b001, 3'b001, 32'hA5A5A5A5);
    l1d_req_rdy = 1'b1;
    tick();
    l1d_req_rdy = 1'b0;
    chk("pre_rst_busy", {31'b0, core_req_rdy}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", {31'b0, core_req_rdy}, 32'd1);
    chk("arst_addr", l1d_req_addr, 32'h0);
    chk("arst_wdata", l1d_req_wdata, 32'h0);
    chk("arst_size", {29'b0, l1d_req_size}, 32'd0);
    chk("arst_cop", {29'b0, l1d_req_cop}, 32'd0);
    chk("arst_val", {31'b0, l1d_req_val}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    l1d_ack = 1'b1; l1d_ack_rdata = 32'h1234ABCD;
    tick();
    l1d_ack = 1'b0;
    chk("post_rst_ack", {31'b0, core_ack}, 32'd0);
    tick();
    chk("post_rst_ack2", {31'b0, core_ack}, 32'd0);
    chk("post_rst_rdata", core_ack_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
